cal_continue: RTL and testbench
===============================

Name: cal_continue

Overview:
- Computes the length of the longest run of consecutive 1 bits in a 32-bit data word.
- Used as a datapath helper unit, for example as a count-run ALU extension in the pipelined CPU.
- Fully pipelined with one registered stage and a simple valid handshake.
- Can accept a new word every cycle.

Parameters:
- WIDTH, 32: data word width in bits. Must be ≥2.
- RW, 6: result width. Must satisfy 2^RW > WIDTH, so that a count of WIDTH is representable. For WIDTH=32 this gives 6.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  data is presented this cycle and must be processed.
- data  input  WIDTH  word to analyse; bit WIDTH-1 is the MSB.
- result  output  RW  length of the longest run of consecutive 1s in the last accepted word.
- out_valid  output  1  result corresponds to the word accepted on the previous clock edge.

Behaviour:
- Function: result = max over all maximal runs of adjacent 1 bits in data of the run length.
  - All-zero word → 0.
  - All-ones word → WIDTH (32).
  - Bit order is irrelevant to the count.
  - No wrap-around: bit 0 and bit WIDTH-1 are not adjacent.
- Reset: when rst_n=0, result←0 and out_valid←0 immediately (asynchronous), regardless of clk. Both hold at these values while rst_n stays low.
- Release: the first rising edge after rst_n deasserts is a normal cycle.
- Capture:
  - On a rising edge with in_valid=1: result←f(data) and out_valid←1.
  - On a rising edge with in_valid=0: out_valid←0 and result holds its previous value.
- Latency: exactly 1 cycle from the accepting edge to the visible result and out_valid.
- Throughput: 1 word per cycle. There is no backpressure and no ready signal; every in_valid=1 cycle is consumed.
- Back-to-back words: each edge overwrites result with the newest word's count, and out_valid stays high.
- Reset mid-stream: an in-flight result is discarded. out_valid=0 after reset, and a word presented during reset is not captured.
- Implementation freedom:
  - Computation is combinational between the input and the output register.
  - A scan or tree counter is allowed: a running counter clears on 0 and increments on 1, combined with a running max.
  - It must meet a single-cycle path at the CPU clock.
  - No multicycle iteration is allowed.
- data is don't-care when in_valid=0. X on data with in_valid=0 must not corrupt result.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle → result=0 and out_valid=0 before the next edge. Release, hold in_valid=0 → outputs stay 0.
- Mixed runs: in_valid=1, data=32'b0000_0011_1111_1000_0000_1111_0101_0000 (0x03F80F50) → next cycle result=7, out_valid=1.
- Extremes, back-to-back:
  - data=0x00000000 → 0.
  - then 0xFFFFFFFF → 32.
  - then 0xAAAAAAAA → 1.
  - Each result appears one cycle after its word, and out_valid stays high throughout.
- No wrap and edge runs:
  - 0x80000001 → 1, not 2.
  - 0xFFFF0000 → 16.
  - 0x7FFFFFFF → 31.
  - 0x0000000F → 4.
- Hold behaviour: after data=0x00FF0000 (result 8), drop in_valid for 3 cycles with random data → result stays 8, out_valid=0.
- Randomised: 1000 random words with random in_valid, checked against a reference longest-run model at 1-cycle latency. Include an rst_n pulse mid-stream → the next valid result is correct and no stale out_valid appears.

Source files
------------

// File: rtl/cal_continue.sv
// rtl/cal_continue.sv - longest run of consecutive 1 bits in a data word, one registered stage
module cal_continue #(
  parameter int WIDTH = 32,
  parameter int RW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data,
  output logic [RW-1:0]    result,
  output logic             out_valid
);

  localparam logic [RW-1:0] ONE = RW'(1);

  logic [RW-1:0] run_len;
  logic [RW-1:0] best_len;
  logic [RW-1:0] result_d, result_q;
  logic          valid_d, valid_q;

  // Single-pass scan: the running count clears on a 0, and the best count tracks its peak.
  always_comb begin
    run_len  = '0;
    best_len = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        run_len = run_len + ONE;
      end else begin
        run_len = '0;
      end
      if (run_len > best_len) begin
        best_len = run_len;
      end
    end
  end

  always_comb begin
    result_d = result_q;
    valid_d  = in_valid;
    if (in_valid) begin
      result_d = best_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_cal_continue.sv
// tb/tb_cal_continue.sv - directed table, multi-cycle corner cases and random stream for cal_continue
module tb_cal_continue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] data;
  logic [5:0]  result;
  logic        out_valid;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic [5:0]  exp_res;
    logic        exp_vld;
  } vec_t;

  vec_t vecs[$];

  cal_continue #(.WIDTH(32), .RW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data      (data),
    .result    (result),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each pass strips the lowest bit of every run; the pass count is the longest run.
  function automatic int ref_run(input logic [31:0] w);
    logic [31:0] x;
    int n;
    x = w;
    n = 0;
    while (x != 32'd0) begin
      x = x & (x << 1);
      n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [5:0] act_res, input logic act_vld,
                       input logic [5:0] exp_res, input logic exp_vld);
    n_checks++;
    if (act_res !== exp_res || act_vld !== exp_vld) begin
      n_fail++;
      $display("FAIL %s: got result=%0d out_valid=%0b, expected result=%0d out_valid=%0b",
               name, act_res, act_vld, exp_res, exp_vld);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] d, input logic [5:0] r, input logic ev);
    vec_t t;
    t.vld = v; t.dat = d; t.exp_res = r; t.exp_vld = ev;
    vecs.push_back(t);
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    in_valid = v;
    data     = d;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] m_res;
  logic       m_vld;
  logic [31:0] rd;
  logic        rv;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data     = 32'd0;

    add(1'b1, 32'h03F80F50, 6'd7,  1'b1);
    add(1'b1, 32'h00000000, 6'd0,  1'b1);
    add(1'b1, 32'hFFFFFFFF, 6'd32, 1'b1);
    add(1'b1, 32'hAAAAAAAA, 6'd1,  1'b1);
    add(1'b1, 32'h80000001, 6'd1,  1'b1);
    add(1'b1, 32'hFFFF0000, 6'd16, 1'b1);
    add(1'b1, 32'h7FFFFFFF, 6'd31, 1'b1);
    add(1'b1, 32'h0000000F, 6'd4,  1'b1);
    add(1'b1, 32'h7FFE7FFF, 6'd15, 1'b1);
    add(1'b1, 32'h00FF0000, 6'd8,  1'b1);
    add(1'b0, $urandom,     6'd8,  1'b0);
    add(1'b0, $urandom,     6'd8,  1'b0);
    add(1'b0, $urandom,     6'd8,  1'b0);
    add(1'b1, 32'h00000001, 6'd1,  1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", result, out_valid, 6'd0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 32'hFFFFFFFF);
    check("idle_after_release_0", result, out_valid, 6'd0, 1'b0);
    step(1'b0, 32'h12345678);
    check("idle_after_release_1", result, out_valid, 6'd0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].dat);
      check($sformatf("vec%0d_%h", i, vecs[i].dat), result, out_valid,
            vecs[i].exp_res, vecs[i].exp_vld);
    end

    // Asynchronous reset mid-cycle, then a word presented while reset is held.
    step(1'b1, 32'hFFFFFFFF);
    check("pre_async_reset", result, out_valid, 6'd32, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_midcycle", result, out_valid, 6'd0, 1'b0);
    step(1'b1, 32'h0000FFFF);
    check("word_during_reset", result, out_valid, 6'd0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 32'h0000FFFF);
    check("first_after_reset", result, out_valid, 6'd16, 1'b1);

    m_res = 6'd16;
    m_vld = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: rd = $urandom;
        1: rd = $urandom & $urandom;
        2: rd = $urandom | $urandom | $urandom;
        default: rd = ~(32'd1 << $urandom_range(0, 31));
      endcase
      step(rv, rd);
      if (rv) begin
        m_res = 6'(ref_run(rd));
      end
      m_vld = rv;
      check($sformatf("rand%0d_%h", k, rd), result, out_valid, m_res, m_vld);
      if (k == 500) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand_reset_pulse", result, out_valid, 6'd0, 1'b0);
        rst_n = 1'b1;
        m_res = 6'd0;
        m_vld = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
